// File: rtl/alu_n2t_pkg.sv
// Shared definitions for the Hack ALU arbiter: control-word bit positions,
// common control words and the arbiter state encoding.
package alu_n2t_pkg;

  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  localparam logic [5:0] ALU_ZERO   = 6'b101010;
  localparam logic [5:0] ALU_NEG1   = 6'b111010;
  localparam logic [5:0] ALU_ADD    = 6'b000010;
  localparam logic [5:0] ALU_SUB_XY = 6'b010011;
  localparam logic [5:0] ALU_SUB_YX = 6'b000111;
  localparam logic [5:0] ALU_AND    = 6'b000000;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/alu_n2t.sv
// Combinational Hack ALU: optional zero/invert of each operand, add or AND,
// optional output invert, plus zero and negative flags.
module alu_n2t
  import alu_n2t_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       c,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_f;

  // NOTE: every variable gets a value at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_x = c[ZX] ? '0 : x;
    w_y = c[ZY] ? '0 : y;
    if (c[NX]) w_x = ~w_x;
    if (c[NY]) w_y = ~w_y;
    w_f = c[F] ? (w_x + w_y) : (w_x & w_y);
  end

  assign out = c[NO] ? ~w_f : w_f;
  assign zr  = (out == '0);
  assign ng  = out[WIDTH-1];

endmodule

// File: rtl/alu_arbiter_n2t.sv
// Round-robin arbiter sharing one Hack ALU between NREQ requesters; each
// grant is followed one cycle later by a done pulse carrying the result.
module alu_arbiter_n2t
  import alu_n2t_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] x_in,
  input  logic [NREQ*WIDTH-1:0] y_in,
  input  logic [NREQ*6-1:0]     c_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      out,
  output logic                  zr,
  output logic                  ng,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NREQ);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] r_sel;
  logic [PTR_W-1:0] w_sel_idx;
  logic [PTR_W-1:0] w_cand;
  logic             w_any_req;
  logic             w_load;
  logic             w_commit;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [NREQ-1:0]  r_done;
  logic [NREQ-1:0]  w_done_nxt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [5:0]       r_c;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic [WIDTH-1:0] w_alu_out;
  logic             w_alu_zr;
  logic             w_alu_ng;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_any_req = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (req[w_cand]) begin
        w_any_req = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt          = EXEC;
          w_gnt_nxt[w_sel_idx] = 1'b1;
          w_load               = 1'b1;
        end
      end
      EXEC: begin
        w_state_nxt       = IDLE;
        w_done_nxt[r_sel] = 1'b1;
        w_ptr_nxt         = PTR_W'((int'(r_sel) + 1) % NREQ);
        w_commit          = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_out   <= '0;
      r_zr    <= 1'b0;
      r_ng    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      if (w_commit) begin
        r_out <= w_alu_out;
        r_zr  <= w_alu_zr;
        r_ng  <= w_alu_ng;
      end
    end
  end

  // NOTE: operand capture registers carry no reset; they are only consumed
  // in EXEC, which is always preceded by a load.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_sel <= w_sel_idx;
      r_x   <= x_in[int'(w_sel_idx)*WIDTH +: WIDTH];
      r_y   <= y_in[int'(w_sel_idx)*WIDTH +: WIDTH];
      r_c   <= c_in[int'(w_sel_idx)*6 +: 6];
    end
  end

  alu_n2t #(
    .WIDTH(WIDTH)
  ) u_alu (
    .x  (r_x),
    .y  (r_y),
    .c  (r_c),
    .out(w_alu_out),
    .zr (w_alu_zr),
    .ng (w_alu_ng)
  );

  assign gnt  = r_gnt;
  assign done = r_done;
  assign out  = r_out;
  assign zr   = r_zr;
  assign ng   = r_ng;
  assign busy = (r_state == EXEC);

endmodule

// File: tb/tb_alu_arbiter_n2t.sv
// Self-checking bench for alu_arbiter_n2t: transaction-level reference model
// compared every cycle, plus directed operations with literal expectations.
module tb_alu_arbiter_n2t;
  import alu_n2t_pkg::*;

  localparam int W    = 16;
  localparam int NREQ = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] x_in;
  logic [NREQ*W-1:0] y_in;
  logic [NREQ*6-1:0] c_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      out;
  logic              zr;
  logic              ng;
  logic              busy;

  alu_arbiter_n2t #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk (clk),
    .reset(reset),
    .req (req),
    .x_in(x_in),
    .y_in(y_in),
    .c_in(c_in),
    .gnt (gnt),
    .done(done),
    .out (out),
    .zr  (zr),
    .ng  (ng),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written directly from the control-word rules.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                           input logic [5:0] cv);
    logic [W-1:0] a, b, r;
    a = cv[5] ? '0 : xv;
    if (cv[4]) a = ~a;
    b = cv[3] ? '0 : yv;
    if (cv[2]) b = ~b;
    r = cv[1] ? W'(a + b) : (a & b);
    if (cv[0]) r = ~r;
    return r;
  endfunction

  function automatic int find_next(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] result_for(input int i);
    return alu_ref(x_in[i*W +: W], y_in[i*W +: W], c_in[i*6 +: 6]);
  endfunction

  // Transaction-level model: one operation in flight at most, result due the
  // cycle after its grant, pointer advances past the requester just served.
  logic            m_valid = 1'b0;
  int              m_inflight = -1;
  int              m_ptr = 0;
  logic [W-1:0]    m_res = '0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [NREQ-1:0] m_done = '0;
  logic [W-1:0]    m_out = '0;
  logic            m_zr = 1'b0;
  logic            m_ng = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b1;
      m_inflight <= -1;
      m_ptr      <= 0;
      m_gnt      <= '0;
      m_done     <= '0;
      m_out      <= '0;
      m_zr       <= 1'b0;
      m_ng       <= 1'b0;
    end else if (m_inflight >= 0) begin
      m_gnt      <= '0;
      m_done     <= NREQ'(1) << m_inflight;
      m_out      <= m_res;
      m_zr       <= (m_res == '0);
      m_ng       <= m_res[W-1];
      m_ptr      <= (m_inflight + 1) % NREQ;
      m_inflight <= -1;
    end else begin
      m_done <= '0;
      if (find_next(req, m_ptr) >= 0) begin
        m_inflight <= find_next(req, m_ptr);
        m_gnt      <= NREQ'(1) << find_next(req, m_ptr);
        m_res      <= result_for(find_next(req, m_ptr));
      end else begin
        m_gnt <= '0;
      end
    end
  end

  int gnt_log[$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'(m_inflight >= 0));
      check("out", 32'(out), 32'(m_out));
      check("zr", 32'(zr), 32'(m_zr));
      check("ng", 32'(ng), 32'(m_ng));
      check("gnt_done_excl", 32'(gnt & done), 32'd0);
    end
    if (gnt != '0) gnt_log.push_back(gnt[1] ? 1 : 0);
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [5:0] cv);
    x_in[idx*W +: W] = xv;
    y_in[idx*W +: W] = yv;
    c_in[idx*6 +: 6] = cv;
  endtask

  // Called just after a rising edge with the DUT idle; returns likewise.
  task automatic do_op(input string name, input int idx, input logic [W-1:0] xv,
                       input logic [W-1:0] yv, input logic [5:0] cv,
                       input logic [W-1:0] eo, input logic ezr, input logic eng);
    set_ops(idx, xv, yv, cv);
    req      = '0;
    req[idx] = 1'b1;
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    check({name, "_gnt"}, 32'(gnt), 32'(1 << idx));
    check({name, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({name, "_done"}, 32'(done), 32'(1 << idx));
    check({name, "_gnt_low"}, 32'(gnt), 32'd0);
    check({name, "_out"}, 32'(out), 32'(eo));
    check({name, "_zr"}, 32'(zr), 32'(ezr));
    check({name, "_ng"}, 32'(ng), 32'(eng));
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ctab [6];

  initial begin
    ctab = '{ALU_ZERO, ALU_NEG1, ALU_ADD, ALU_SUB_XY, ALU_SUB_YX, ALU_AND};
    reset = 1'b1;
    req   = '0;
    x_in  = '0;
    y_in  = '0;
    c_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", 32'({zr, ng}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    do_op("add",     0, 16'd5,    16'd3,    ALU_ADD,    16'd8,    1'b0, 1'b0);
    do_op("sub_xy",  0, 16'd5,    16'd3,    ALU_SUB_XY, 16'd2,    1'b0, 1'b0);
    do_op("sub_yx",  1, 16'd5,    16'd3,    ALU_SUB_YX, 16'hFFFE, 1'b0, 1'b1);
    do_op("zero",    0, 16'd5,    16'd3,    ALU_ZERO,   16'h0000, 1'b1, 1'b0);
    do_op("neg1",    1, 16'd5,    16'd3,    ALU_NEG1,   16'hFFFF, 1'b0, 1'b1);
    do_op("wrap",    0, 16'hFFFF, 16'd1,    ALU_ADD,    16'h0000, 1'b1, 1'b0);
    do_op("and",     1, 16'hF0F0, 16'h0FF0, ALU_AND,    16'h00F0, 1'b0, 1'b0);

    // Both requesters pending from reset: strict alternation.
    do_reset();
    set_ops(0, 16'd100, 16'd7, ALU_SUB_XY);
    set_ops(1, 16'd40,  16'd2, ALU_ADD);
    gnt_log.delete();
    req = 2'b11;
    repeat (8) @(posedge clk);
    #1 req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("simul_count", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_log.size()) check("simul_order", 32'(gnt_log[k]), 32'(k % 2));
    end

    // Requester 1 held, requester 0 pulsed while 1 is in flight.
    do_reset();
    gnt_log.delete();
    req = 2'b10;
    @(posedge clk);
    #1 req = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1 req = 2'b10;
    repeat (5) @(posedge clk);
    #1 req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("fair_count", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_log.size()) check("fair_order", 32'(gnt_log[k]), (k == 1) ? 32'd0 : 32'd1);
    end

    // Reset during EXEC discards the op and returns the pointer to 0.
    do_op("pre_rst", 0, 16'd9, 16'd4, ALU_ADD, 16'd13, 1'b0, 1'b0);
    set_ops(1, 16'd1, 16'd1, ALU_ADD);
    req = 2'b10;
    @(posedge clk);
    #1 req = '0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_gnt", 32'(gnt), 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_gnt_low", 32'(gnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    set_ops(0, 16'd20, 16'd22, ALU_ADD);
    req = 2'b11;
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    check("midrst_ptr0", 32'(gnt), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("midrst_after_out", 32'(out), 32'd42);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional reset.
    for (int cyc = 0; cyc < 400; cyc++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i, W'($urandom), W'($urandom),
                ($urandom_range(0, 1) == 0) ? ctab[$urandom_range(0, 5)] : 6'($urandom));
      end
      reset = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    req   = '0;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter_n2t.md
# alu_arbiter_n2t

Shares one 16-bit Hack ALU between NREQ requesters using a round-robin req/gnt/done handshake. Sits between the CPU datapath and auxiliary units (e.g. address generator, test sequencer) that need ALU cycles. It latches operands and the 6-bit control word, evaluates them in one cycle, and returns the registered result with the zr and ng flags to the granted requester.

## Interface
- WIDTH, 16, data word width
- NREQ, 2, number of requesters (legal 2..4)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- req  input  NREQ  request, one bit per requester
- x_in  input  NREQ*WIDTH  x operand; requester i at bits [i*WIDTH +: WIDTH]
- y_in  input  NREQ*WIDTH  y operand, same packing
- c_in  input  NREQ*6  control {zx,nx,zy,ny,f,no}; requester i at [i*6 +: 6]
- gnt  output  NREQ  one-hot, one-cycle grant
- done  output  NREQ  one-hot, one-cycle result-valid
- out  output  WIDTH  last result, held until the next done
- zr  output  1  out == 0
- ng  output  1  out[WIDTH-1]
- busy  output  1  high while the FSM is in EXEC

## Operation
- FSM states: IDLE, EXEC.
- IDLE: if any req bit is high, pick the first set bit searching from ptr upward, modulo NREQ. Latch that requester's x, y and c. Set gnt[i]. Go to EXEC. If no req bit is high, stay in IDLE.
- EXEC: the ALU evaluates the latched operands. Register out, zr and ng. Set done[i] and clear gnt. Set ptr to (i+1) mod NREQ. Return to IDLE.
- req is sampled only in IDLE and ignored in EXEC.
- A requester that keeps req high after done is re-arbitrated normally. Because ptr has advanced, other pending requesters win first.
- A req that drops before being sampled gets no grant and no state change.
- ALU semantics, applied in order:
  - zx: x = 0; then nx: x = ~x.
  - zy: y = 0; then ny: y = ~y.
  - f=1: sum = x + y, modulo 2^WIDTH, carry discarded; f=0: x & y.
  - no: invert the result.
  - zr = (out == 0); ng = out MSB.
- Reset values: state IDLE, ptr 0, gnt 0, done 0, busy 0, out 0, zr 0, ng 0.
- Reset asserted during EXEC discards the operation: no done pulse, out is unchanged apart from being reset to 0.
- Reset has priority over any simultaneous req.

## Timing
- Edge t (IDLE, req sampled) → gnt and busy high during cycle t+1.
- Edge t+1 → done, out, zr and ng valid during cycle t+2. gnt and busy are low in cycle t+2.
- Earliest next grant: sampled at edge t+2, so gnt is high in cycle t+3. Peak throughput is one operation per 2 cycles.
- Operands must be valid together with req at the sampling edge. They may change freely after gnt.
- gnt and done are never high together, and never for more than one cycle.

## Structure
- Package alu_n2t_pkg holds:
  - control bit indices ZX=5, NX=4, ZY=3, NY=2, F=1, NO=0
  - constants ALU_ZERO=6'b101010, ALU_NEG1=6'b111010, ALU_ADD=6'b000010, ALU_SUB_XY=6'b010011, ALU_SUB_YX=6'b000111, ALU_AND=6'b000000
  - the state enum {IDLE, EXEC}
- Sub-module alu_n2t: purely combinational, with ports x, y, c → out, zr, ng. The arbiter instantiates it once.

## Test plan
- Single op: req[0]=1, x=5, y=3, c=ALU_ADD → gnt[0] in cycle t+1, done[0] in cycle t+2, out=8, zr=0, ng=0.
- Subtraction, zero and flags, each as separate ops:
  - x=5, y=3, ALU_SUB_XY → out=2.
  - ALU_SUB_YX → out=16'hFFFE, ng=1.
  - ALU_ZERO → out=0, zr=1.
  - ALU_NEG1 → out=16'hFFFF, ng=1.
- Wrap-around: x=16'hFFFF, y=1, ALU_ADD → out=0, zr=1. ALU_AND with x=16'hF0F0, y=16'h0FF0 → 16'h00F0.
- Simultaneous requests: both req high from reset → grant order 0, 1, 0, 1. Each done matches its own operands.
- Fairness: req[1] held high, req[0] pulsed once → req[0] is served after the in-flight op for requester 1. Requester 1 is never starved.
- Reset mid-op: assert reset in cycle t+1 (gnt high) → no done pulse. Next cycle shows out=0, gnt=0, ptr=0. A fresh req is then served normally.
